// File: rtl/uart_rx_oversampler.sv
// ----------------------------------------------------------------------------
// uart_rx_oversampler
//
// Oversampling bit recoverer for the UART receive path. Each bit period is
// `scale` clocks long. Inside every period the block counts how many of
// NUM_SAMPLES consecutive samples, centred on mid-bit, saw the line high.
// On the last clock of the period it issues a registered majority-vote bit.
// The bit comes with a one-cycle valid strobe and a flag that is set when the
// samples disagreed.
//
// Parameters
//   NUM_SAMPLES : samples per bit, odd, 1..7 (K = (NUM_SAMPLES-1)/2)
//   SCALE_W     : width of the scale (clocks-per-bit) input
//
// Ports
//   clk       : system clock
//   rst       : asynchronous reset, active low
//   sdata     : serial RX line, already synchronised to clk
//   samp_en   : enable; low holds the block idle and discards any partial bit
//   scale     : clocks per bit; legal when scale >= 2K+2
//   samp_out  : majority-vote bit (registered)
//   bit_valid : one-cycle strobe, samp_out/noise_err were just updated
//   noise_err : samples of the last bit were not unanimous
//   cfg_err   : scale is too small for NUM_SAMPLES (registered)
//   edge_cnt  : current clock position within the bit, 0..scale-1
// ----------------------------------------------------------------------------
module uart_rx_oversampler #(
   parameter int NUM_SAMPLES = 3,
   parameter int SCALE_W     = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               sdata,
   input  logic               samp_en,
   input  logic [SCALE_W-1:0] scale,
   output logic               samp_out,
   output logic               bit_valid,
   output logic               noise_err,
   output logic               cfg_err,
   output logic [SCALE_W-1:0] edge_cnt
);

   localparam int K     = (NUM_SAMPLES - 1) / 2;
   localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

   // Constants pre-sized so every arithmetic operand has the same width.
   localparam logic [SCALE_W-1:0] K_S       = SCALE_W'(K);
   localparam logic [SCALE_W-1:0] ONE_S     = SCALE_W'(1);
   localparam logic [SCALE_W:0]   MIN_SCALE = (SCALE_W + 1)'(2 * K + 2);
   localparam logic [CNT_W-1:0]   K_C       = CNT_W'(K);
   localparam logic [CNT_W-1:0]   ALL_C     = CNT_W'(NUM_SAMPLES);
   localparam logic [CNT_W-1:0]   ONE_C     = CNT_W'(1);

   logic [CNT_W-1:0]   ones_cnt;

   logic               cfg_bad;
   logic [SCALE_W-1:0] half;
   logic [SCALE_W-1:0] win_lo;
   logic [SCALE_W-1:0] win_hi;
   logic               in_window;
   logic               at_end;
   logic               running;

   // Configuration check and sampling window. The bad-scale condition gates
   // the datapath directly, so a too-small scale stops counting on the very
   // clock it appears. The registered cfg_err only reports it one clock later.
   // While the scale is legal, half >= K+1 holds, so win_lo never underflows.
   // Also win_hi <= scale-2, so no sample ever lands on the decision edge.
   always_comb begin
      cfg_bad   = ({1'b0, scale} < MIN_SCALE);
      half      = scale >> 1;
      win_lo    = half - K_S - ONE_S;
      win_hi    = half + K_S - ONE_S;
      in_window = (edge_cnt >= win_lo) && (edge_cnt <= win_hi);
      at_end    = (edge_cnt >= (scale - ONE_S));
      running   = samp_en && !cfg_bad;
   end

   // Configuration error flag, refreshed every clock whether or not the
   // block is enabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_bad;
      end
   end

   // Bit-period position counter. The wrap uses >= rather than == on purpose.
   // If scale shrinks below the current position mid-bit, the counter wraps
   // on the next clock instead of running round the full counter range.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_cnt <= '0;
      end else if (!running || at_end) begin
         edge_cnt <= '0;
      end else begin
         edge_cnt <= edge_cnt + ONE_S;
      end
   end

   // Count of high samples seen so far in the current bit. It clears on the
   // decision edge. That edge is never inside the window, so nothing is lost
   // by clearing instead of sampling there.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ones_cnt <= '0;
      end else if (!running || at_end) begin
         ones_cnt <= '0;
      end else if (in_window && sdata) begin
         ones_cnt <= ones_cnt + ONE_C;
      end
   end

   // Bit decision. samp_out and noise_err change only together with the
   // valid strobe. They hold their last value while idle, so the frame FSM
   // can still read the previous bit after dropping samp_en.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         samp_out  <= 1'b0;
         noise_err <= 1'b0;
         bit_valid <= 1'b0;
      end else if (running && at_end) begin
         samp_out  <= (ones_cnt > K_C);
         noise_err <= !((ones_cnt == '0) || (ones_cnt == ALL_C));
         bit_valid <= 1'b1;
      end else begin
         bit_valid <= 1'b0;
      end
   end

endmodule
